overdrive_scheduler: RTL and testbench

//  Time-multiplexes one fixed_multiply instance to apply the cubic overdrive curve to a frame of

---
 rtl/overdrive_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_overdrive_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/overdrive_scheduler.sv
// overdrive_scheduler: applies the cubic overdrive curve to a frame of CHANNELS samples.
// One shared fixed-point multiplier is time-multiplexed by the FSM. For each channel it
// computes x^2, then x^3, then (3x + x^3) >>> 2. Samples at or beyond +/-ONE clamp to +/-HALF.
// Bypass frames pass through unchanged.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input frame handshake; in_data packs channel i at [32*i+31:32*i]
//   bypass                sampled with the frame; 1 = pass samples unmodified
//   out_valid/out_ready   output frame handshake; out_data uses the same packing
//   busy                  high whenever the FSM is not idle

// fixed_multiply: lower 32 bits of the signed 64-bit product shifted right by FRAC_BITS.
module fixed_multiply #(
    parameter int unsigned FRAC_BITS = 12
) (
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] p_c
);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] full;

    assign a_ext = 64'(a);
    assign b_ext = 64'(b);
    assign full  = a_ext * b_ext;
    assign p_c   = 32'(full >>> FRAC_BITS);
endmodule

module overdrive_scheduler #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned FRAC_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [32*CHANNELS-1:0]   in_data,
    input  logic                     bypass,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [32*CHANNELS-1:0]   out_data,
    output logic                     busy
);
    localparam int unsigned DW   = 32 * CHANNELS;
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [31:0] ONE  = 32'(64'(2) << FRAC_BITS);
    localparam logic signed [31:0] HALF = 32'(64'(1) << FRAC_BITS);
    localparam logic [CH_W-1:0]    LAST = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CUBE,
        S_SUM,
        S_OUT
    } state_t;

    state_t             state, state_d;
    logic [CH_W-1:0]    ch, ch_d;
    logic [DW-1:0]      frame, frame_d;
    logic               byp, byp_d;
    logic signed [31:0] sq, sq_d;
    logic signed [31:0] cube, cube_d;
    logic [DW-1:0]      out_data_d;
    logic               out_valid_d;
    logic               busy_d;

    logic signed [31:0] x;
    logic signed [31:0] mul_a, mul_b, mul_p;
    logic signed [31:0] sum;
    logic signed [31:0] res;
    logic               wr_res;

    assign in_ready = (state == S_IDLE) && rst_n;
    assign x        = frame[32*int'(ch) +: 32];

    fixed_multiply #(.FRAC_BITS(FRAC_BITS)) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .p_c (mul_p)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch        <= '0;
            frame     <= '0;
            byp       <= 1'b0;
            sq        <= '0;
            cube      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ch        <= ch_d;
            frame     <= frame_d;
            byp       <= byp_d;
            sq        <= sq_d;
            cube      <= cube_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Next-state, operand mux and result write-back
    always_comb begin
        state_d     = state;
        ch_d        = ch;
        frame_d     = frame;
        byp_d       = byp;
        sq_d        = sq;
        cube_d      = cube;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        mul_a       = x;
        mul_b       = x;
        sum         = x + x + x + cube;
        res         = '0;
        wr_res      = 1'b0;

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    frame_d = in_data;
                    byp_d   = bypass;
                    ch_d    = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (byp) begin
                    res    = x;
                    wr_res = 1'b1;
                end else if (x >= ONE) begin
                    res    = HALF;
                    wr_res = 1'b1;
                end else if (x <= -ONE) begin
                    res    = -HALF;
                    wr_res = 1'b1;
                end else begin
                    sq_d    = mul_p;
                    state_d = S_CUBE;
                end
            end
            S_CUBE: begin
                mul_a   = sq;
                cube_d  = mul_p;
                state_d = S_SUM;
            end
            S_SUM: begin
                res    = sum >>> 2;
                wr_res = 1'b1;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Store the channel result and advance to the next channel or the output stage
        if (wr_res) begin
            out_data_d[32*int'(ch) +: 32] = res;
            if (ch == LAST) begin
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end else begin
                ch_d    = ch + CH_W'(1);
                state_d = S_CHECK;
            end
        end

        busy_d = (state_d != S_IDLE);
    end
endmodule

// File: tb/tb_overdrive_scheduler.sv
// Self-checking bench for overdrive_scheduler (CHANNELS=2, FRAC_BITS=12).
// Directed frames from the datasheet plus randomized frames checked against a plain
// arithmetic model of the overdrive curve and latency rule.
module tb_overdrive_scheduler;
    localparam int unsigned CH = 2;
    localparam int unsigned FB = 12;
    localparam int ONE_I  = 2 << FB;
    localparam int HALF_I = 1 << FB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [32*CH-1:0] in_data;
    logic            bypass;
    logic            out_valid;
    logic            out_ready;
    logic [32*CH-1:0] out_data;
    logic            busy;

    int total = 0;
    int bad   = 0;

    overdrive_scheduler #(.CHANNELS(CH), .FRAC_BITS(FB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Overdrive curve per sample, straight from the arithmetic definition
    function automatic logic [31:0] model(input logic [31:0] xin, input bit byp);
        int x, sq, cube, s;
        x = int'(xin);
        if (byp) return xin;
        if (x >= ONE_I) return 32'(HALF_I);
        if (x <= -ONE_I) return 32'(-HALF_I);
        sq   = int'((longint'(x) * longint'(x)) >>> FB);
        cube = int'((longint'(sq) * longint'(x)) >>> FB);
        s    = 3 * x + cube;
        return 32'(s >>> 2);
    endfunction

    function automatic int model_k(input logic [31:0] d0, input logic [31:0] d1, input bit byp);
        int k;
        k = 0;
        if (byp || int'(d0) >= ONE_I || int'(d0) <= -ONE_I) k += 1; else k += 3;
        if (byp || int'(d1) >= ONE_I || int'(d1) <= -ONE_I) k += 1; else k += 3;
        return k;
    endfunction

    // Send one frame, measure latency, hold backpressure, then complete the output transfer
    task automatic run_frame(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input bit byp, input int hold);
        logic [63:0] exp_data;
        logic [63:0] seen;
        int k;
        exp_data = {model(d1, byp), model(d0, byp)};
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = {d1, d0};
        bypass   = byp;
        @(posedge clk);
        #1;
        chk({tag, ".busy_after_accept"}, 64'(busy), 64'(1));
        // Source keeps presenting unrelated data while busy; it must be ignored
        in_data = ~{d1, d0};
        bypass  = ~byp;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 64'(k), 64'(model_k(d0, d1, byp)));
        chk({tag, ".data"}, out_data, exp_data);
        seen = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ".hold_data"}, out_data, seen);
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 64'(out_valid), 64'(0));
        chk({tag, ".in_ready_after"}, 64'(in_ready), 64'(1));
        chk({tag, ".busy_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [31:0] r0, r1;
        bit          rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        bypass    = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset.out_valid", 64'(out_valid), 64'(0));
        chk("reset.out_data", out_data, 64'(0));
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_frame("clamp_pos", 32'h0000_3000, 32'h0000_0800, 1'b0, 0);
        chk("clamp_pos.const", out_data, 64'h0000_0680_0000_1000);
        run_frame("clamp_neg", 32'hFFFF_E000, 32'hFFFF_F800, 1'b0, 1);
        chk("clamp_neg.const", out_data, 64'hFFFF_F980_FFFF_F000);
        run_frame("no_clamp", 32'h0000_1FFF, 32'h0000_0000, 1'b0, 0);
        chk("no_clamp.const", out_data, 64'h0000_0000_0000_37FC);
        run_frame("bypass", 32'h7FFF_FFFF, 32'h0000_0800, 1'b1, 0);
        chk("bypass.const", out_data, 64'h0000_0800_7FFF_FFFF);
        run_frame("after_bypass", 32'h0000_0800, 32'h0000_2000, 1'b0, 0);
        chk("after_bypass.const", out_data, 64'h0000_1000_0000_0680);
        run_frame("backpressure", 32'hFFFF_F800, 32'h0000_1FFF, 1'b0, 5);

        // Reset while the first channel is in S_CUBE
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {32'h0000_0400, 32'h0000_0800};
        bypass   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset.busy", 64'(busy), 64'(0));
        chk("midreset.out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("midreset.quiet", 64'(out_valid), 64'(0));
        end
        run_frame("post_reset", 32'h0000_0800, 32'hFFFF_E001, 1'b0, 0);

        // Randomized frames biased toward the clamp thresholds
        for (int n = 0; n < 24; n++) begin
            r0 = 32'($urandom);
            r1 = 32'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    r0 = 32'(int'($urandom_range(0, 2 * ONE_I)) - ONE_I);
                    r1 = 32'(int'($urandom_range(0, 2 * ONE_I)) - ONE_I);
                end
                1: begin
                    r0 = ($urandom_range(0, 1) != 0) ? 32'(ONE_I - 1) : 32'(-ONE_I + 1);
                    r1 = ($urandom_range(0, 1) != 0) ? 32'(ONE_I) : 32'(-ONE_I);
                end
                default: ;
            endcase
            rb = ($urandom_range(0, 3) == 0);
            run_frame("random", r0, r1, rb, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
